// File: rtl/layer_input_loader.sv
`default_nettype none
// ============================================================================
// Module   : layer_input_loader
// Brief    : Collects NUM_INPUTS serial signed samples into a parallel frame
//            and hands it to a dense layer. Optional framing check via
//            LAYER_INPUT_LAST_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module layer_input_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
`ifdef LAYER_INPUT_LAST_CHECK_EN
    input  logic                         in_last,
`endif
    output logic                         in_ready,
    input  logic                         layer_done,
    output logic signed [DATA_WIDTH-1:0] inputs [NUM_INPUTS],
    output logic                         inputs_ready,
    output logic                         busy,
    output logic                         frame_error
);

    localparam int                   c_count_w    = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [c_count_w-1:0] c_last_idx   = c_count_w'(NUM_INPUTS - 1);
    localparam logic [1:0]           c_st_fill    = 2'd0;
    localparam logic [1:0]           c_st_present = 2'd1;
    localparam logic [1:0]           c_st_wait    = 2'd2;

    logic [1:0]                   r_state;
    logic [1:0]                   w_next_state;
    logic [c_count_w-1:0]         r_count;
    logic signed [DATA_WIDTH-1:0] r_inputs [NUM_INPUTS];
    logic                         w_at_last;
    logic                         w_store;
    logic                         w_wrap;
`ifdef LAYER_INPUT_LAST_CHECK_EN
    logic                         w_error;
    logic                         r_frame_error;
`endif

    assign w_at_last = (r_count == c_last_idx);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_fill;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        inputs_ready = 1'b0;
        busy         = 1'b0;
        w_store      = 1'b0;
        w_wrap       = 1'b0;
`ifdef LAYER_INPUT_LAST_CHECK_EN
        w_error      = 1'b0;
`endif
        case (r_state)
            c_st_fill: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef LAYER_INPUT_LAST_CHECK_EN
                    // A last flag that disagrees with the position aborts the frame.
                    if (in_last != w_at_last) begin
                        w_error = 1'b1;
                        w_wrap  = 1'b1;
                    end else begin
                        w_store = 1'b1;
                        if (w_at_last) begin
                            w_wrap       = 1'b1;
                            w_next_state = c_st_present;
                        end
                    end
`else
                    w_store = 1'b1;
                    if (w_at_last) begin
                        w_wrap       = 1'b1;
                        w_next_state = c_st_present;
                    end
`endif
                end
            end
            c_st_present: begin
                inputs_ready = 1'b1;
                busy         = 1'b1;
                w_next_state = c_st_wait;
            end
            c_st_wait: begin
                busy = 1'b1;
                if (layer_done) begin
                    w_next_state = c_st_fill;
                end
            end
            default: begin
                w_next_state = c_st_fill;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                r_inputs[i] <= '0;
            end
        end else begin
            if (w_store) begin
                r_inputs[r_count] <= in_data;
            end
            if (w_wrap) begin
                r_count <= '0;
            end else if (w_store) begin
                r_count <= r_count + c_count_w'(1);
            end
        end
    end

`ifdef LAYER_INPUT_LAST_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_frame_error <= 1'b0;
        end else begin
            r_frame_error <= w_error;
        end
    end
    assign frame_error = r_frame_error;
`else
    assign frame_error = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_out
            assign inputs[gi] = r_inputs[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_layer_input_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_input_loader
// Brief    : Self-checking bench for layer_input_loader (NUM_INPUTS=4,
//            DATA_WIDTH=16) against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_input_loader;

    localparam int DW = 16;
    localparam int N  = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic signed [DW-1:0] in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic                 layer_done;
    logic signed [DW-1:0] inputs [N];
    logic                 inputs_ready;
    logic                 busy;
    logic                 frame_error;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame held/presented flags, fill position, visible array.
    bit                   m_held;
    bit                   m_present;
    bit                   m_err;
    int                   m_cnt;
    logic signed [DW-1:0] m_mem [N];

    layer_input_loader #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
`ifdef LAYER_INPUT_LAST_CHECK_EN
        .in_last      (in_last),
`endif
        .in_ready     (in_ready),
        .layer_done   (layer_done),
        .inputs       (inputs),
        .inputs_ready (inputs_ready),
        .busy         (busy),
        .frame_error  (frame_error)
    );

    always #5 clock = ~clock;

    // Drive one cycle of stimulus, advance the model, return 1 time unit after the edge.
    task automatic step(input bit rst, input bit v, input logic signed [DW-1:0] d,
                        input bit done, input bit last);
        reset      = rst;
        in_valid   = v;
        in_data    = d;
        layer_done = done;
        in_last    = last;
        m_err      = 1'b0;
        if (rst) begin
            m_held = 0; m_present = 0; m_cnt = 0;
            foreach (m_mem[i]) m_mem[i] = '0;
        end else if (m_present) begin
            m_present = 0;
        end else if (m_held) begin
            if (done) m_held = 0;
        end else if (v) begin
`ifdef LAYER_INPUT_LAST_CHECK_EN
            if (last != (m_cnt == N - 1)) begin
                m_err = 1'b1;
                m_cnt = 0;
            end else
`endif
            begin
                m_mem[m_cnt] = d;
                m_cnt++;
                if (m_cnt == N) begin
                    m_cnt = 0; m_held = 1; m_present = 1;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        bit bad;
        step(1, 0, '0, 0, 0);
        step(1, 1, 16'sd77, 1, 0);
        bad = 0;
        foreach (inputs[i]) if (inputs[i] !== 16'sd0) bad = 1;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || inputs_ready !== 1'b0 || frame_error !== 1'b0 || bad) begin
            n_fail++;
            $display("FAIL reset: rdy=%b busy=%b ir=%b fe=%b arr_zero=%b; want 1 0 0 0 1",
                     in_ready, busy, inputs_ready, frame_error, !bad);
        end
    endtask

    task automatic test_basic();
        logic signed [DW-1:0] s [4];
        logic signed [DW-1:0] d;
        int pulse_at;
        bit bad;
        s[0] = 16'sd5; s[1] = -16'sd3; s[2] = 16'sd7; s[3] = 16'sd0;
        pulse_at = -1;
        step(1, 0, '0, 0, 0);
        for (int c = 0; c < 16; c++) begin
            d = (c < 4) ? s[c] : 16'sd99;
            step(0, 1, d, (c == 14), 0);
            if (inputs_ready === 1'b1 && pulse_at < 0) pulse_at = c;
            bad = 0;
            foreach (m_mem[i]) if (inputs[i] !== m_mem[i]) bad = 1;
            n_checks++;
            if (in_ready !== !m_held || busy !== m_held || inputs_ready !== m_present || frame_error !== m_err || bad) begin
                n_fail++;
                $display("FAIL basic cyc%0d: rdy=%b busy=%b ir=%b fe=%b arr_ok=%b; want %b %b %b %b 1",
                         c, in_ready, busy, inputs_ready, frame_error, !bad, !m_held, m_held, m_present, m_err);
            end
            if (c == 3) begin
                bad = 0;
                foreach (s[i]) if (inputs[i] !== s[i]) bad = 1;
                n_checks++;
                if (bad || busy !== 1'b1 || in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_frame: inputs=%0d,%0d,%0d,%0d busy=%b rdy=%b; want 5,-3,7,0 1 0",
                             inputs[0], inputs[1], inputs[2], inputs[3], busy, in_ready);
                end
            end
        end
        n_checks++;
        if (pulse_at != 3) begin
            n_fail++;
            $display("FAIL basic_latency: pulse after cycle %0d; want 3", pulse_at);
        end
        n_checks++;
        if (inputs[0] !== 16'sd99 || inputs[1] !== -16'sd3) begin
            n_fail++;
            $display("FAIL wait_hold_next: inputs[0]=%0d inputs[1]=%0d; want 99 -3", inputs[0], inputs[1]);
        end
    endtask

    task automatic test_toggle();
        int pulses, k, pulse_at;
        bit bad, v;
        pulses = 0; k = 0; pulse_at = -1;
        step(1, 0, '0, 0, 0);
        for (int c = 0; c < 8; c++) begin
            v = (c % 2 == 0);
            step(0, v, v ? DW'(k + 1) : 16'sd555, 0, 0);
            if (v) k++;
            if (inputs_ready === 1'b1) begin pulses++; pulse_at = c; end
            bad = 0;
            foreach (m_mem[i]) if (inputs[i] !== m_mem[i]) bad = 1;
            n_checks++;
            if (in_ready !== !m_held || busy !== m_held || inputs_ready !== m_present || frame_error !== m_err || bad) begin
                n_fail++;
                $display("FAIL toggle cyc%0d: rdy=%b busy=%b ir=%b fe=%b arr_ok=%b; want %b %b %b %b 1",
                         c, in_ready, busy, inputs_ready, frame_error, !bad, !m_held, m_held, m_present, m_err);
            end
        end
        n_checks++;
        if (pulses != 1 || pulse_at != 6 || inputs[0] !== 16'sd1 || inputs[1] !== 16'sd2 ||
            inputs[2] !== 16'sd3 || inputs[3] !== 16'sd4) begin
            n_fail++;
            $display("FAIL toggle_frame: pulses=%0d at %0d inputs=%0d,%0d,%0d,%0d; want 1 at 6, 1,2,3,4",
                     pulses, pulse_at, inputs[0], inputs[1], inputs[2], inputs[3]);
        end
    endtask

    task automatic test_reset_mid();
        logic signed [DW-1:0] d;
        int pulses;
        bit bad;
        pulses = 0;
        step(1, 0, '0, 0, 0);
        for (int c = 0; c < 9; c++) begin
            d = (c < 2) ? DW'(c + 50) : DW'((c - 2) * 10);
            step(c == 2, 1, d, 0, 0);
            if (inputs_ready === 1'b1) pulses++;
            bad = 0;
            foreach (m_mem[i]) if (inputs[i] !== m_mem[i]) bad = 1;
            n_checks++;
            if (in_ready !== !m_held || busy !== m_held || inputs_ready !== m_present || frame_error !== m_err || bad) begin
                n_fail++;
                $display("FAIL reset_mid cyc%0d: rdy=%b busy=%b ir=%b fe=%b arr_ok=%b; want %b %b %b %b 1",
                         c, in_ready, busy, inputs_ready, frame_error, !bad, !m_held, m_held, m_present, m_err);
            end
        end
        n_checks++;
        if (pulses != 1 || inputs[0] !== 16'sd10 || inputs[1] !== 16'sd20 ||
            inputs[2] !== 16'sd30 || inputs[3] !== 16'sd40) begin
            n_fail++;
            $display("FAIL reset_mid_frame: pulses=%0d inputs=%0d,%0d,%0d,%0d; want 1, 10,20,30,40",
                     pulses, inputs[0], inputs[1], inputs[2], inputs[3]);
        end
    endtask

    task automatic test_back_to_back();
        int pulses, first_at, second_at;
        bit bad;
        pulses = 0; first_at = -1; second_at = -1;
        step(1, 0, '0, 0, 0);
        for (int c = 0; c < 14; c++) begin
            step(0, 1, DW'($urandom), 1, 0);
            if (inputs_ready === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = c; else if (second_at < 0) second_at = c;
            end
            bad = 0;
            foreach (m_mem[i]) if (inputs[i] !== m_mem[i]) bad = 1;
            n_checks++;
            if (in_ready !== !m_held || busy !== m_held || inputs_ready !== m_present || frame_error !== m_err || bad) begin
                n_fail++;
                $display("FAIL b2b cyc%0d: rdy=%b busy=%b ir=%b fe=%b arr_ok=%b; want %b %b %b %b 1",
                         c, in_ready, busy, inputs_ready, frame_error, !bad, !m_held, m_held, m_present, m_err);
            end
        end
        n_checks++;
        if (pulses != 2 || second_at - first_at != N + 2) begin
            n_fail++;
            $display("FAIL b2b_period: pulses=%0d period=%0d; want 2 and %0d",
                     pulses, second_at - first_at, N + 2);
        end
    endtask

    task automatic test_random();
        bit bad, v, done, rst, last;
        step(1, 0, '0, 0, 0);
        for (int c = 0; c < 400; c++) begin
            rst  = ($urandom_range(0, 99) == 0);
            v    = ($urandom_range(0, 9) < 7);
            done = ($urandom_range(0, 9) < 3);
            last = (m_cnt == N - 1);
`ifdef LAYER_INPUT_LAST_CHECK_EN
            if ($urandom_range(0, 19) == 0) last = !last;
`endif
            step(rst, v, DW'($urandom), done, last);
            bad = 0;
            foreach (m_mem[i]) if (inputs[i] !== m_mem[i]) bad = 1;
            n_checks++;
            if (in_ready !== !m_held || busy !== m_held || inputs_ready !== m_present || frame_error !== m_err || bad) begin
                n_fail++;
                $display("FAIL random cyc%0d: rdy=%b busy=%b ir=%b fe=%b arr_ok=%b; want %b %b %b %b 1",
                         c, in_ready, busy, inputs_ready, frame_error, !bad, !m_held, m_held, m_present, m_err);
            end
        end
    endtask

`ifdef LAYER_INPUT_LAST_CHECK_EN
    task automatic test_last();
        int errs, pulses;
        bit bad;
        errs = 0; pulses = 0;
        step(1, 0, '0, 0, 0);
        for (int c = 0; c < 6; c++) begin
            step(0, 1, DW'(c + 1), 0, (c == 1) || (c == 5));
            if (frame_error === 1'b1) errs++;
            if (inputs_ready === 1'b1) pulses++;
            bad = 0;
            foreach (m_mem[i]) if (inputs[i] !== m_mem[i]) bad = 1;
            n_checks++;
            if (in_ready !== !m_held || busy !== m_held || inputs_ready !== m_present || frame_error !== m_err || bad) begin
                n_fail++;
                $display("FAIL last cyc%0d: rdy=%b busy=%b ir=%b fe=%b arr_ok=%b; want %b %b %b %b 1",
                         c, in_ready, busy, inputs_ready, frame_error, !bad, !m_held, m_held, m_present, m_err);
            end
        end
        n_checks++;
        if (errs != 1 || pulses != 1) begin
            n_fail++;
            $display("FAIL last_summary: errors=%0d pulses=%0d; want 1 1", errs, pulses);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; layer_done = 1'b0; in_last = 1'b0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_toggle();
        test_reset_mid();
        test_back_to_back();
`ifdef LAYER_INPUT_LAST_CHECK_EN
        test_last();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
